credit_receiver_fifo: RTL and testbench

Parametrised credit-flow receiver. Buffers incoming push-side flits in a DEPTH-entry FIFO and tracks the credits it holds as a multi-bit counter. Returns one credit per cycle to the sender, subject to stall and withhold. It sits at the receive end of a credit-based link, between the link sender and a ready/valid consumer.

---
 rtl/credit_receiver_fifo.sv | 127 ++++++++++++
 tb/tb_credit_receiver_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/credit_receiver_fifo.sv
// Purpose : receive end of a credit link; buffers flits in a DEPTH-entry FIFO and returns held credits.
// Latency : a flit pushed at edge N is poppable in cycle N+1. A credit is returned as a combinational pulse, at most one per cycle.
// Backpressure: pop side is valid/ready. Push side relies on credits; a push into a full FIFO (no same-cycle pop) is dropped and flags overflow.
//
// Ports:
//   clk, rst                   clock, async active-high reset
//   push_sender_in_reset       sender in reset: synchronous flush of FIFO and credits
//   push_receiver_in_reset     registered "receiver in reset" indication to sender
//   push_valid/push_data       incoming flit
//   push_credit_stall          suppress credit return this cycle
//   push_credit                one-credit return pulse
//   credit_initial             credits loaded on reset release / flush (0..DEPTH)
//   credit_withhold            credits kept in reserve
//   credit_count               credits held, not yet returned
//   credit_available           credit_count > credit_withhold
//   pop_valid/pop_ready/pop_data  head of FIFO to consumer
//   occupancy                  FIFO entries in use
//   overflow                   sticky: a push arrived with no free entry
module credit_receiver_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_sender_in_reset,
    output logic                  push_receiver_in_reset,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  push_credit_stall,
    output logic                  push_credit,
    input  logic [CW-1:0]         credit_initial,
    input  logic [CW-1:0]         credit_withhold,
    output logic [CW-1:0]         credit_count,
    output logic                  credit_available,
    output logic                  pop_valid,
    input  logic                  pop_ready,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic [CW-1:0]         occupancy,
    output logic                  overflow
);

    localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         occ_q;
    logic [CW-1:0]         occ_next;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_next;
    logic                  in_reset;
    logic                  pop_fire;
    logic                  push_fire;
    logic                  push_accepted;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_C) ? '0 : p + PW'(1);
    endfunction

    assign in_reset = push_receiver_in_reset | push_sender_in_reset;

    // While the receiver is held in reset the visible count follows credit_initial;
    // the register captures it on the release edge (receiver-reset flop still set).
    assign credit_count     = push_receiver_in_reset ? credit_initial : cnt_q;
    assign credit_available = credit_count > credit_withhold;
    assign push_credit      = credit_available & ~push_credit_stall & ~in_reset;

    assign pop_valid = (occ_q != '0);
    assign pop_data  = mem[rd_ptr];
    assign occupancy = occ_q;

    assign pop_fire      = pop_valid & pop_ready & ~in_reset;
    assign push_fire     = push_valid & ~in_reset;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_accepted = push_fire & ((occ_q < DEPTH_C) | pop_fire);

    always_comb begin
        cnt_next = cnt_q;
        if (pop_fire && !push_credit) begin
            if (cnt_q != DEPTH_C) cnt_next = cnt_q + CW'(1);
        end else if (push_credit && !pop_fire) begin
            if (cnt_q != '0) cnt_next = cnt_q - CW'(1);
        end
    end

    always_comb begin
        occ_next = occ_q;
        if (push_accepted && !pop_fire)      occ_next = occ_q + CW'(1);
        else if (!push_accepted && pop_fire) occ_next = occ_q - CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) push_receiver_in_reset <= 1'b1;
        else     push_receiver_in_reset <= 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ_q    <= '0;
            cnt_q    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (in_reset) begin
            // Flush: traffic ignored, overflow deliberately kept.
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
            cnt_q  <= credit_initial;
        end else begin
            if (push_accepted) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_fire) rd_ptr <= ptr_inc(rd_ptr);
            occ_q <= occ_next;
            cnt_q <= cnt_next;
            if (push_fire && !push_accepted) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_credit_receiver_fifo.sv
module tb_credit_receiver_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          push_sender_in_reset;
    logic          push_receiver_in_reset;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_credit_stall;
    logic          push_credit;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic          credit_available;
    logic          pop_valid;
    logic          pop_ready;
    logic [DW-1:0] pop_data;
    logic [CW-1:0] occupancy;
    logic          overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int sat_viol = 0;

    credit_receiver_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .push_sender_in_reset   (push_sender_in_reset),
        .push_receiver_in_reset (push_receiver_in_reset),
        .push_valid             (push_valid),
        .push_data              (push_data),
        .push_credit_stall      (push_credit_stall),
        .push_credit            (push_credit),
        .credit_initial         (credit_initial),
        .credit_withhold        (credit_withhold),
        .credit_count           (credit_count),
        .credit_available       (credit_available),
        .pop_valid              (pop_valid),
        .pop_ready              (pop_ready),
        .pop_data               (pop_data),
        .occupancy              (occupancy),
        .overflow               (overflow)
    );

    always #5 clk = ~clk;

    // Credit count must never exceed DEPTH.
    always @(negedge clk) if (credit_count > CW'(DEPTH)) sat_viol++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] exp_q [4];

    initial begin
        rst = 1'b1; push_sender_in_reset = 0; push_valid = 0; push_data = '0;
        push_credit_stall = 0; credit_initial = CW'(4); credit_withhold = '0; pop_ready = 0;

        // 1: reset values and initial credit return
        #12;
        chk("rst_rir", push_receiver_in_reset, 1);
        chk("rst_pop_valid", pop_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_pop_data", pop_data, 0);
        chk("rst_credit", push_credit, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_cnt", credit_count, 4);
        rst = 1'b0;
        step();
        chk("rel_rir", push_receiver_in_reset, 0);
        for (int i = 0; i < 4; i++) begin
            chk("init_pc", push_credit, 1);
            chk("init_cnt", credit_count, 32'(4 - i));
            step();
        end
        chk("init_cnt_end", credit_count, 0);
        chk("init_pc_end", push_credit, 0);

        // 2: fill, overflow, drain in order
        for (int i = 0; i < 4; i++) begin
            push_valid = 1; push_data = DW'(8'h11 * (i + 1));
            step();
        end
        chk("fill_occ", occupancy, 4);
        chk("fill_ovf", overflow, 0);
        chk("fill_head", pop_data, 8'h11);
        push_data = 8'h55;
        step();
        chk("drop_ovf", overflow, 1);
        chk("drop_occ", occupancy, 4);
        push_valid = 0; pop_ready = 1;
        #1;
        chk("drain_pc0", push_credit, 0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", pop_data, 32'(8'h11 * (i + 1)));
            step();
            chk("drain_cnt", credit_count, 1);
            chk("drain_pc", push_credit, 1);
        end
        chk("drain_empty", pop_valid, 0);
        pop_ready = 0;
        step();
        chk("drain_cnt_end", credit_count, 0);
        chk("ovf_sticky", overflow, 1);

        // 3: push into full FIFO with simultaneous pop
        for (int i = 0; i < 4; i++) begin
            push_valid = 1; push_data = DW'(i + 1);
            step();
        end
        push_data = 8'h66; pop_ready = 1;
        #1;
        chk("fullpop_head", pop_data, 8'h01);
        step();
        chk("fullpop_occ", occupancy, 4);
        chk("fullpop_ovf", overflow, 1);
        push_valid = 0;
        exp_q[0] = 8'h02; exp_q[1] = 8'h03; exp_q[2] = 8'h04; exp_q[3] = 8'h66;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("fullpop_data", pop_data, 32'(exp_q[i]));
            step();
        end
        pop_ready = 0;
        step();
        chk("s3_cnt", credit_count, 0);

        // 4: withhold and stall
        credit_withhold = CW'(3);
        for (int i = 0; i < 3; i++) begin
            push_valid = 1; push_data = DW'(8'h71 + i);
            step();
        end
        push_valid = 0; pop_ready = 1;
        step(); step(); step();
        pop_ready = 0;
        chk("wh_cnt", credit_count, 3);
        chk("wh_avail", credit_available, 0);
        chk("wh_pc", push_credit, 0);
        step();
        chk("wh_hold", credit_count, 3);
        credit_withhold = CW'(1);
        #1;
        chk("rel_pc1", push_credit, 1);
        step();
        chk("rel_pc2", push_credit, 1);
        chk("rel_cnt2", credit_count, 2);
        step();
        chk("rel_pc3", push_credit, 0);
        chk("rel_cnt1", credit_count, 1);
        credit_withhold = '0; push_credit_stall = 1;
        #1;
        chk("stall_avail", credit_available, 1);
        chk("stall_pc", push_credit, 0);
        step(); step();
        chk("stall_cnt", credit_count, 1);

        // 5: sender flush with occupancy 2, count 1
        push_valid = 1; push_data = 8'h81; step();
        push_data = 8'h82; step();
        chk("pre_flush_occ", occupancy, 2);
        chk("pre_flush_cnt", credit_count, 1);
        push_credit_stall = 0; push_sender_in_reset = 1; push_data = 8'h99;
        #1;
        chk("flush_pc", push_credit, 0);
        step();
        push_sender_in_reset = 0; push_valid = 0;
        #1;
        chk("flush_occ", occupancy, 0);
        chk("flush_pv", pop_valid, 0);
        chk("flush_cnt", credit_count, 4);
        chk("flush_ovf", overflow, 1);

        // 6: async reset mid-transfer, then zero initial credit
        push_valid = 1; push_data = 8'hAB; step();
        #3;
        rst = 1; credit_initial = '0;
        #1;
        chk("arst_rir", push_receiver_in_reset, 1);
        chk("arst_pv", pop_valid, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_pd", pop_data, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_pc", push_credit, 0);
        push_valid = 0;
        step();
        #2 rst = 0;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("zero_pc", push_credit, 0);
            chk("zero_avail", credit_available, 0);
            step();
        end
        chk("zero_cnt", credit_count, 0);
        chk("no_saturation", sat_viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
